alog_pipe: RTL and testbench
============================

# alog_pipe

Parametrised, pipelined antilog (2^x) converter for the log-domain datapath of the TFLAF filters. It converts a signed fixed-point base-2 logarithm into an unsigned linear magnitude. It generalises the fixed Q3.12 combinational antilog with:
- configurable input and output formats;
- round-half-up;
- saturation and underflow flags;
- sign and tag sideband;
- a two-stage valid/ready pipeline with back-pressure.

It sits between the log-domain MAC and the linear-domain error/update logic.

## Interface
Parameters:
- IW, 6: integer bits of the log input, two's complement, including sign.
- FW, 12: fractional bits of the log input.
- OUT_W, 15: output magnitude width, unsigned.
- OUT_FW, 12: fractional bits of the output.
- RND, 1: 1 = round half up on right shifts; 0 = truncate.
- TAG_W, 4: sideband tag width (channel/tap index), passed through unchanged.

Ports:
- clk  in  1  clock; all registers update on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  block accepts the input this cycle.
- in_data  in  IW+FW  signed log2 value, Q(IW).(FW).
- in_sgn  in  1  sign of the linear value, passed through.
- in_tag  in  TAG_W  sideband, passed through.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accepts the output.
- out_data  out  OUT_W  linear magnitude, Q(OUT_W-OUT_FW).(OUT_FW).
- out_sgn  out  1  registered in_sgn.
- out_tag  out  TAG_W  registered in_tag.
- out_ovf  out  1  result saturated.
- out_uf  out  1  result is zero (underflow).

## Operation
- Decode the input fields:
  - exponent e = in_data[IW+FW-1:FW], signed;
  - mantissa m = {1'b1, in_data[FW-1:0]}, FW+1 bits, value 1.f.
- Compute the shift amount s = e + OUT_FW - FW, signed, IW+2 bits so it cannot overflow.
- Stage 1 registers m, s, sgn and tag.
- s >= 0: r = m << s, computed in OUT_W+FW+1 bits.
  - Any set bit at or above position OUT_W forces out_data = all ones and out_ovf = 1.
- s < 0: r = m >> (-s).
  - RND=1: add the bit m[-s-1].
  - If the rounding carry reaches bit OUT_W, saturate to all ones with out_ovf = 1.
  - -s >= FW+2: r = 0 regardless of RND.
- Underflow: out_uf = 1 exactly when the final r == 0. out_ovf and out_uf are never both 1.
- Stage 2 registers r and the flags, with sgn and tag carried alongside.
- Every input is mapped. There is no default-to-zero hole for large exponents: large exponents saturate, small ones flush to zero.

## Timing
Latency and pipeline:
- Latency is 2 cycles from acceptance (in_valid & in_ready) to out_valid, with no stall.
- Throughput is 1 word/cycle while out_ready = 1.
- Per-stage valids v1, v2. Stage enables en2 = !v2 | out_ready and en1 = !v1 | en2.
- in_ready = en1, combinational from out_ready and the valids.
- Stage 1 loads when en1; v1 <= in_valid.
- Stage 2 loads when en2; v2 <= v1.
- out_valid = v2.

Handshake rules:
- While out_valid & !out_ready, all out_* signals hold stable.
- Up to 2 words are buffered. With both stages full and out_ready = 0, in_ready = 0.
- Simultaneous accept and emit in the same cycle is lossless and preserves order.

Reset:
- On rst_n low, immediately and asynchronously, v1, v2, out_valid, out_data, out_sgn, out_tag, out_ovf and out_uf all go to 0.
- In-flight words are discarded.
- in_ready = 1 while in reset.
- The first acceptance can occur on the first rising edge after rst_n goes high.

## Test plan
All scenarios use default parameters.
- Basic values, out_ready = 1, checked on out_valid 2 cycles after in_valid:
  - in_data = 18'h00000 -> out_data = 15'h1000, ovf = 0, uf = 0.
  - 18'h02000 -> 15'h4000.
  - 18'h02FFF -> 15'h7FFC.
- Saturation: in_data = 18'h03000 (e = 3) -> out_data = 15'h7FFF, out_ovf = 1. Same result for 18'h1F000 (e = +31).
- Rounding at RND=1: 18'h3F001 (e = -1, m = 13'h1001) -> 15'h0801. The same input with RND=0 -> 15'h0800. Also 18'h33000 (e = -13) -> 1, uf = 0.
- Underflow: 18'h32000 (e = -14) -> out_data = 0, out_uf = 1. 18'h20000 (e = -32) -> 0, out_uf = 1.
- Back-pressure:
  - Stimulus: stream tags 1..5 back-to-back, hold out_ready = 0 for 4 cycles, then release.
  - Required: in_ready drops after two accepts and out_* hold stable. All 5 words emerge in tag order with none dropped or duplicated, and sgn and tag match their data.
- Reset mid-stream: assert rst_n low between clock edges with both stages full -> out_valid = 0 and out_data = 0 without waiting for a clock edge. After release, the first new word is seen 2 cycles after its acceptance.

Source files
------------

// File: rtl/alog_pipe.sv
// alog_pipe: pipelined antilog (2^x) converter, log domain -> linear magnitude.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid / in_ready    input handshake
//   in_data  [IW+FW-1:0]   signed log2 value, Q(IW).(FW)
//   in_sgn, in_tag         sideband, passed through
//   out_valid / out_ready  output handshake
//   out_data [OUT_W-1:0]   linear magnitude, Q(OUT_W-OUT_FW).(OUT_FW)
//   out_sgn, out_tag       registered sideband
//   out_ovf, out_uf        saturated / flushed-to-zero flags
//
// Stage 1 decodes exponent/mantissa and shift amount; stage 2 shifts, rounds,
// saturates and flags. Two-entry valid/ready pipeline with back-pressure.
module alog_pipe #(
    parameter int IW     = 6,
    parameter int FW     = 12,
    parameter int OUT_W  = 15,
    parameter int OUT_FW = 12,
    parameter int RND    = 1,
    parameter int TAG_W  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IW+FW-1:0]    in_data,
    input  logic                in_sgn,
    input  logic [TAG_W-1:0]    in_tag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OUT_W-1:0]    out_data,
    output logic                out_sgn,
    output logic [TAG_W-1:0]    out_tag,
    output logic                out_ovf,
    output logic                out_uf
);
    // Wide enough for the largest in-range left shift of the mantissa.
    localparam int WIDE = OUT_W + FW + 1;
    localparam int SOFF = OUT_FW - FW;
    localparam logic signed [IW+1:0] SOFF_V = SOFF[IW+1:0];

    logic                   en1, en2, v1, v2;
    logic [FW:0]            m1;
    logic signed [IW+1:0]   s1;
    logic                   sgn1;
    logic [TAG_W-1:0]       tag1;
    logic [IW+1:0]          s_in;

    // Two extra bits of sign extension so e + offset cannot wrap.
    assign s_in = {{2{in_data[IW+FW-1]}}, in_data[IW+FW-1:FW]} + SOFF_V;

    assign en2       = !v2 || out_ready;
    assign en1       = !v1 || en2;
    assign in_ready  = en1;
    assign out_valid = v2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1   <= 1'b0;
            m1   <= '0;
            s1   <= '0;
            sgn1 <= 1'b0;
            tag1 <= '0;
        end else if (en1) begin
            v1   <= in_valid;
            m1   <= {1'b1, in_data[FW-1:0]};
            s1   <= s_in;
            sgn1 <= in_sgn;
            tag1 <= in_tag;
        end
    end

    logic [WIDE-1:0]  w;
    logic             big, rbit, ovf_c, uf_c;
    logic [OUT_W-1:0] r_c;
    int               sh;

    always_comb begin
        sh   = int'(s1);
        w    = '0;
        big  = 1'b0;
        rbit = 1'b0;
        if (sh >= 0) begin
            // Mantissa MSB lands at FW+sh >= OUT_W: saturate without
            // letting the wide shift drop the leading one.
            if (sh >= OUT_W) big = 1'b1;
            else             w   = WIDE'(m1) << sh;
        end else if (-sh < FW + 2) begin
            // Round half up: add the last bit shifted out.
            rbit = |(WIDE'(m1) & (WIDE'(1) << (-sh - 1)));
            w    = (WIDE'(m1) >> (-sh)) + ((RND != 0) ? WIDE'(rbit) : '0);
        end
        // Shifts of FW+2 or more leave w = 0 (flush).
        ovf_c = big || (|w[WIDE-1:OUT_W]);
        r_c   = ovf_c ? '1 : w[OUT_W-1:0];
        uf_c  = !ovf_c && (r_c == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2       <= 1'b0;
            out_data <= '0;
            out_sgn  <= 1'b0;
            out_tag  <= '0;
            out_ovf  <= 1'b0;
            out_uf   <= 1'b0;
        end else if (en2) begin
            v2       <= v1;
            out_data <= r_c;
            out_sgn  <= sgn1;
            out_tag  <= tag1;
            out_ovf  <= ovf_c;
            out_uf   <= uf_c;
        end
    end
endmodule

// File: tb/tb_alog_pipe.sv
// tb_alog_pipe: scoreboard bench for alog_pipe. Two instances (rounding and
// truncating) share the input stream; expected words are queued on accept
// and a monitor pops/compares on every output transfer.
module tb_alog_pipe;
    localparam int IW = 6, FW = 12, OUT_W = 15, OUT_FW = 12, TAG_W = 4;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        in_valid = 1'b0, in_sgn = 1'b0, out_ready = 1'b1;
    logic [17:0] in_data = '0;
    logic [3:0]  in_tag = '0;

    logic        in_ready, out_valid, out_sgn, out_ovf, out_uf;
    logic [14:0] out_data;
    logic [3:0]  out_tag;
    logic        in_ready_t, out_valid_t, out_sgn_t, out_ovf_t, out_uf_t;
    logic [14:0] out_data_t;
    logic [3:0]  out_tag_t;

    alog_pipe #(.IW(IW), .FW(FW), .OUT_W(OUT_W), .OUT_FW(OUT_FW), .RND(1), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_sgn(in_sgn), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sgn(out_sgn), .out_tag(out_tag), .out_ovf(out_ovf), .out_uf(out_uf));

    alog_pipe #(.IW(IW), .FW(FW), .OUT_W(OUT_W), .OUT_FW(OUT_FW), .RND(0), .TAG_W(TAG_W)) dut_t (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_t),
        .in_data(in_data), .in_sgn(in_sgn), .in_tag(in_tag),
        .out_valid(out_valid_t), .out_ready(out_ready), .out_data(out_data_t),
        .out_sgn(out_sgn_t), .out_tag(out_tag_t), .out_ovf(out_ovf_t), .out_uf(out_uf_t));

    always #5 clk = ~clk;

    typedef struct packed {
        logic [14:0] data;
        logic        sgn;
        logic [3:0]  tag;
        logic        ovf;
        logic        uf;
    } exp_t;

    exp_t q_rnd[$], q_trn[$];
    int   ncmp = 0, nerr = 0;
    bit   rand_rdy = 1'b0;

    task automatic check(input string name, input longint act, input longint req);
        ncmp++;
        if (act != req) begin
            nerr++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: value * 2^OUT_FW = m * 2^(e + OUT_FW - FW), rounded half up
    // or truncated, clamped to the output range.
    function automatic exp_t model(input logic [17:0] d, input logic s,
                                   input logic [3:0] t, input bit rnd);
        exp_t   x;
        int     k, n;
        longint m, v;
        longint maxv = (64'sd1 <<< OUT_W) - 1;
        k = int'($signed(d[17:12])) + OUT_FW - FW;
        m = longint'({1'b1, d[11:0]});
        if (k >= 0) v = (k > 40) ? maxv + 1 : (m <<< k);
        else begin
            n = -k;
            v = rnd ? ((m + (64'sd1 <<< (n - 1))) >>> n) : (m >>> n);
        end
        x.ovf  = (v > maxv);
        x.data = x.ovf ? 15'h7FFF : v[14:0];
        x.uf   = (v == 0);
        x.sgn  = s;
        x.tag  = t;
        return x;
    endfunction

    // Entered just after a rising edge; returns just after a rising edge.
    task automatic send(input logic [17:0] d, input logic s, input logic [3:0] t,
                        input exp_t er, input exp_t et);
        int waited = 0;
        in_valid = 1'b1; in_data = d; in_sgn = s; in_tag = t;
        forever begin
            if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (in_ready) begin
                q_rnd.push_back(er);
                q_trn.push_back(et);
                break;
            end
            waited++;
            if (waited > 200) begin
                check("accept_timeout", 0, 1);
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_rand(input logic [3:0] t);
        logic [17:0] d;
        logic        s;
        int          ee;
        d = 18'($urandom);
        s = 1'($urandom);
        if ($urandom_range(0, 1) == 1) begin
            ee = int'($urandom_range(0, 20)) - 16;
            d[17:12] = ee[5:0];
        end
        send(d, s, t, model(d, s, t, 1'b1), model(d, s, t, 1'b0));
    endtask

    task automatic drain();
        int w = 0;
        out_ready = 1'b1;
        while ((q_rnd.size() > 0 || q_trn.size() > 0) && w < 200) begin
            @(posedge clk); #1;
            w++;
        end
        check("drain_left", longint'(q_rnd.size() + q_trn.size()), 0);
    endtask

    // Monitor: pops on each transfer, checks hold-stability while stalled.
    initial begin
        exp_t act, held;
        bit   stalled = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            act = {out_data, out_sgn, out_tag, out_ovf, out_uf};
            if (!rst_n) stalled = 1'b0;
            else begin
                if (stalled) check("hold_stable", {out_valid, act}, {1'b1, held});
                if (out_valid && out_ready) begin
                    if (q_rnd.size() == 0) check("spurious_out", 1, 0);
                    else check("out_rnd", act, q_rnd.pop_front());
                end
                if (out_valid_t && out_ready) begin
                    if (q_trn.size() == 0) check("spurious_out_t", 1, 0);
                    else check("out_trunc",
                               {out_data_t, out_sgn_t, out_tag_t, out_ovf_t, out_uf_t},
                               q_trn.pop_front());
                end
                stalled = out_valid && !out_ready;
                held    = act;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Directed vectors with hand-derived results (rounding / truncating).
    logic [17:0] dir_in  [9] = '{18'h00000, 18'h02000, 18'h02FFF, 18'h03000, 18'h1F000,
                                 18'h3F001, 18'h33000, 18'h32000, 18'h20000};
    logic [14:0] dir_r   [9] = '{15'h1000, 15'h4000, 15'h7FFC, 15'h7FFF, 15'h7FFF,
                                 15'h0801, 15'h0001, 15'h0000, 15'h0000};
    logic [14:0] dir_t   [9] = '{15'h1000, 15'h4000, 15'h7FFC, 15'h7FFF, 15'h7FFF,
                                 15'h0800, 15'h0000, 15'h0000, 15'h0000};
    bit          dir_ovf [9] = '{0, 0, 0, 1, 1, 0, 0, 0, 0};
    bit          dir_ufr [9] = '{0, 0, 0, 0, 0, 0, 0, 1, 1};
    bit          dir_uft [9] = '{0, 0, 0, 0, 0, 0, 1, 1, 1};

    initial begin
        int acc;
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_in_ready", in_ready, 1);
        check("reset_out_word", {out_data, out_sgn, out_tag, out_ovf, out_uf}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed values, back-to-back, out_ready = 1.
        for (int i = 0; i < 9; i++) begin
            logic s;
            logic [3:0] t;
            s = 1'(i);
            t = 4'(i + 3);
            send(dir_in[i], s, t,
                 '{data: dir_r[i], sgn: s, tag: t, ovf: dir_ovf[i], uf: dir_ufr[i]},
                 '{data: dir_t[i], sgn: s, tag: t, ovf: dir_ovf[i], uf: dir_uft[i]});
        end
        drain();

        // Back-pressure: tags 1..5 back-to-back, out_ready low for 4 cycles.
        fork
            begin
                for (int i = 1; i <= 5; i++) send_rand(4'(i));
            end
            begin
                out_ready = 1'b0;
                acc = 0;
                repeat (4) begin
                    @(negedge clk);
                    if (in_valid && in_ready) acc++;
                end
                check("bp_accepts", acc, 2);
                check("bp_in_ready_low", in_ready, 0);
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Random stream with random back-pressure and input gaps.
        rand_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            send_rand(4'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                out_ready = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
            end
        end
        rand_rdy = 1'b0;
        drain();

        // Reset mid-stream with both stages full.
        out_ready = 1'b0;
        send(18'h02000, 1'b1, 4'h9, model(18'h02000, 1'b1, 4'h9, 1'b1),
             model(18'h02000, 1'b1, 4'h9, 1'b0));
        send(18'h3F001, 1'b1, 4'h6, model(18'h3F001, 1'b1, 4'h6, 1'b1),
             model(18'h3F001, 1'b1, 4'h6, 1'b0));
        @(negedge clk);
        check("full_out_valid", out_valid, 1);
        check("full_in_ready", in_ready, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_word", {out_valid, out_data, out_sgn, out_tag, out_ovf, out_uf}, 0);
        check("rst_in_ready", in_ready, 1);
        q_rnd.delete();
        q_trn.delete();
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 18'h00000; in_sgn = 1'b1; in_tag = 4'hA;
        @(negedge clk);
        check("rst_first_accept", in_ready, 1);
        q_rnd.push_back('{data: 15'h1000, sgn: 1'b1, tag: 4'hA, ovf: 1'b0, uf: 1'b0});
        q_trn.push_back('{data: 15'h1000, sgn: 1'b1, tag: 4'hA, ovf: 1'b0, uf: 1'b0});
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("latency_cycle1", out_valid, 0);
        @(negedge clk);
        check("latency_cycle2", out_valid, 1);
        @(posedge clk); #1;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
